// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic array, its operand feeder and the
// result drain.
//   accw_f()        : accumulator width derived from the operand width
//   acc_word_t      : accumulator word at the default operand width
//   drain_state_e   : result-drain tile FSM states
// -----------------------------------------------------------------------------
package systolic_pkg;

    localparam int DATAWIDTH_DEF = 8;

    // A product of two DATAWIDTH operands summed over up to 2^DATAWIDTH terms
    // fits in three operand widths.
    function automatic int accw_f(input int dw);
        return 3 * dw;
    endfunction

    localparam int ACCW_DEF = accw_f(DATAWIDTH_DEF);

    typedef logic [ACCW_DEF-1:0] acc_word_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DRAIN   = 2'd3
    } drain_state_e;

endpackage

// File: rtl/systolic_result_drain_row_fifo.sv
// -----------------------------------------------------------------------------
// row_fifo
// Synchronous FIFO holding de-skewed result rows.
//   clk, rst   : clock, synchronous active-high reset
//   push_i     : write wdata_i (ignored when full unless popping this cycle)
//   pop_i      : remove head entry (ignored when empty)
//   wdata_i    : row to enqueue
//   rdata_o    : head entry, forced to zero while empty
//   full_o     : DEPTH entries held
//   empty_o    : no entries held
// DEPTH must be a power of two, at least 2.
// -----------------------------------------------------------------------------
module row_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // One extra pointer bit tells full from empty when the indices match.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop in the same cycle frees the slot, so a push on a full FIFO
    // still lands when the head is leaving.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; the output gating below hides stale contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/systolic_result_drain.sv
// -----------------------------------------------------------------------------
// systolic_result_drain
// Receive side of the systolic array. Columns leave the array bottom skewed by
// one cycle per column; per-column delay chains re-align them into rows, which
// are queued in a row FIFO and handed downstream on a valid/ready handshake.
//   clk, rst   : clock, synchronous active-high reset
//   start      : one-cycle pulse, tile row 0 enters array row 0 this cycle
//   rows       : tile row count, sampled with an accepted start
//   col_in     : array bottom outputs, one accumulator per column
//   out_row    : aligned result row (FIFO head), zero when none
//   out_valid  : out_row holds a row
//   out_ready  : downstream accepts out_row
//   busy       : tile in progress
//   done       : one-cycle pulse once the whole tile has been delivered
//   overflow   : sticky, at least one aligned row was dropped on a full FIFO
// -----------------------------------------------------------------------------
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int DATAWIDTH  = 8,
    parameter int N_SIZE     = 32,
    parameter int LAT        = N_SIZE,
    parameter int ROW_W      = 9,
    parameter int FIFO_DEPTH = 8,
    localparam int ACCW      = accw_f(DATAWIDTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ROW_W-1:0]             rows,
    input  logic [N_SIZE-1:0][ACCW-1:0]  col_in,
    output logic [N_SIZE-1:0][ACCW-1:0]  out_row,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow
);

    // Row 0 is aligned at the chain outputs LAT+N_SIZE-1 cycles after start.
    // The wait counter holds the cycles still to go before that alignment
    // cycle, so it is loaded one lower for the first WAIT cycle and CAPTURE is
    // entered when it reaches 1. Requires LAT+N_SIZE >= 3.
    localparam int WAIT_LOAD = LAT + N_SIZE - 2;
    localparam int WAIT_W    = $clog2(WAIT_LOAD + 1) + 1;

    // -------------------------------------------------------------------------
    // De-skew: column j is late by N_SIZE-1-j cycles relative to the last
    // column. The array never stalls, so the chains shift every cycle.
    // -------------------------------------------------------------------------
    logic [N_SIZE-1:0][ACCW-1:0] aligned;

    for (genvar j = 0; j < N_SIZE; j++) begin : g_col
        localparam int D = N_SIZE - 1 - j;
        if (D == 0) begin : g_thru
            assign aligned[j] = col_in[j];
        end else begin : g_dly
            logic [D-1:0][ACCW-1:0] sr_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    sr_q <= '0;
                end else begin
                    sr_q[0] <= col_in[j];
                    for (int k = 1; k < D; k++) begin
                        sr_q[k] <= sr_q[k-1];
                    end
                end
            end
            assign aligned[j] = sr_q[D-1];
        end
    end

    // -------------------------------------------------------------------------
    // Row FIFO
    // -------------------------------------------------------------------------
    logic fifo_push, fifo_pop, fifo_full, fifo_empty;

    row_fifo #(
        .WIDTH (N_SIZE * ACCW),
        .DEPTH (FIFO_DEPTH)
    ) u_row_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (aligned),
        .rdata_o (out_row),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign fifo_pop  = out_valid && out_ready;

    // -------------------------------------------------------------------------
    // Tile FSM
    // -------------------------------------------------------------------------
    drain_state_e      state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              ovf_q, ovf_d;
    logic              zdone_q, zdone_d;  // done for a zero-row tile

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        row_d     = row_q;
        ovf_d     = ovf_q;
        zdone_d   = 1'b0;
        fifo_push = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ovf_d = 1'b0;
                    if (rows != '0) begin
                        state_d = ST_WAIT;
                        wait_d  = WAIT_W'(WAIT_LOAD);
                        row_d   = rows;
                    end else begin
                        zdone_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                wait_d = wait_q - WAIT_W'(1);
                if (wait_q == WAIT_W'(1)) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // A row dropped on a full FIFO still counts as captured.
                fifo_push = 1'b1;
                row_d     = row_q - ROW_W'(1);
                if (row_q == ROW_W'(1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (fifo_push && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            row_q   <= '0;
            ovf_q   <= 1'b0;
            zdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            row_q   <= row_d;
            ovf_q   <= ovf_d;
            zdone_q <= zdone_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = ((state_q == ST_DRAIN) && fifo_empty) || zdone_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
module tb_systolic_result_drain;

    localparam int N    = 4;
    localparam int LAT  = 4;
    localparam int DW   = 8;
    localparam int ACCW = 3 * DW;
    localparam int RW   = 9;
    localparam int FD   = 8;

    typedef logic [N-1:0][ACCW-1:0] row_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [RW-1:0] rows;
    row_t          col_in;
    row_t          out_row;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic          overflow;

    int   vectors    = 0;
    int   miscompares = 0;
    row_t exp_q[$];

    systolic_result_drain #(
        .DATAWIDTH  (DW),
        .N_SIZE     (N),
        .LAT        (LAT),
        .ROW_W      (RW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rows      (rows),
        .col_in    (col_in),
        .out_row   (out_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Drives col_in for cycle c of a tile started at cycle t0 following the
    // arrival law (row r, column j at t0+LAT+r+j); everything outside the tile
    // window is random junk. Once the last column of row r has been driven,
    // the row is queued as expected output if it is one of the first `keep`.
    task automatic drive(input int c, input int t0, input int nrows, input int keep);
        row_t e;
        int   r;
        for (int j = 0; j < N; j++) begin
            r = c - t0 - LAT - j;
            if (r >= 0 && r < nrows) col_in[j] = ACCW'(100 * r + j);
            else                     col_in[j] = ACCW'($urandom);
        end
        r = c - t0 - LAT - (N - 1);
        if (r >= 0 && r < keep) begin
            for (int j = 0; j < N; j++) e[j] = ACCW'(100 * r + j);
            exp_q.push_back(e);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] st;
        rst = 1'b1; start = 1'b0; rows = '0; out_ready = 1'b0; col_in = '0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        st = {out_valid, busy, done, overflow};
        vectors++;
        if (st !== 4'b0 || out_row !== '0) begin
            miscompares++;
            $display("FAIL reset_state: valid/busy/done/ovf=%b row=%h, want 0000 row=0", st, out_row);
        end
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            for (int j = 0; j < N; j++) col_in[j] = ACCW'($urandom);
            out_ready = 1'($urandom);
            @(negedge clk);
            st = {out_valid, busy, done, overflow};
            vectors++;
            if (st !== 4'b0 || out_row !== '0) begin
                miscompares++;
                $display("FAIL idle c=%0d: valid/busy/done/ovf=%b row=%h, want 0000 row=0", c, st, out_row);
            end
            next_cycle();
        end
    endtask

    // rows=3, ready high: rows at 8,9,10, done at 11.
    task automatic test_nominal();
        logic [3:0] st, ex;
        for (int c = 0; c < 15; c++) begin
            start = (c == 0); rows = RW'(3); out_ready = 1'b1;
            drive(c, 0, 3, 3);
            @(negedge clk);
            st = {out_valid, busy, done, overflow};
            ex = {(c >= 8 && c <= 10), (c >= 1 && c <= 11), (c == 11), 1'b0};
            vectors++;
            if (st !== ex) begin
                miscompares++;
                $display("FAIL nominal_status c=%0d: valid/busy/done/ovf=%b want %b", c, st, ex);
            end
            if (out_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL nominal_row c=%0d: got %h, want no row", c, out_row);
                end else begin
                    if (out_row !== exp_q[0]) begin
                        miscompares++;
                        $display("FAIL nominal_row c=%0d: got %h want %h", c, out_row, exp_q[0]);
                    end
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            next_cycle();
        end
        start = 1'b0;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL nominal_drain: %0d rows undelivered, want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    // ready low until cycle 15: rows held, delivered 15..17, done at 18.
    task automatic test_backpressure();
        logic [3:0] st, ex;
        for (int c = 0; c < 21; c++) begin
            start = (c == 0); rows = RW'(3); out_ready = (c >= 15);
            drive(c, 0, 3, 3);
            @(negedge clk);
            st = {out_valid, busy, done, overflow};
            ex = {(c >= 8 && c <= 17), (c >= 1 && c <= 18), (c == 18), 1'b0};
            vectors++;
            if (st !== ex) begin
                miscompares++;
                $display("FAIL backpressure_status c=%0d: valid/busy/done/ovf=%b want %b", c, st, ex);
            end
            if (out_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL backpressure_row c=%0d: got %h, want no row", c, out_row);
                end else begin
                    if (out_row !== exp_q[0]) begin
                        miscompares++;
                        $display("FAIL backpressure_row c=%0d: got %h want %h", c, out_row, exp_q[0]);
                    end
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            next_cycle();
        end
        start = 1'b0;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL backpressure_drain: %0d rows undelivered, want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    // rows=10, ready low through capture: rows 8 and 9 dropped at cycles 15,16.
    task automatic test_overflow();
        logic [3:0] st, ex;
        for (int c = 0; c < 31; c++) begin
            start = (c == 0); rows = RW'(10); out_ready = (c >= 20);
            drive(c, 0, 10, FD);
            @(negedge clk);
            st = {out_valid, busy, done, overflow};
            ex = {(c >= 8 && c <= 27), (c >= 1 && c <= 28), (c == 28), (c >= 16)};
            vectors++;
            if (st !== ex) begin
                miscompares++;
                $display("FAIL overflow_status c=%0d: valid/busy/done/ovf=%b want %b", c, st, ex);
            end
            if (out_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL overflow_row c=%0d: got %h, want no row", c, out_row);
                end else begin
                    if (out_row !== exp_q[0]) begin
                        miscompares++;
                        $display("FAIL overflow_row c=%0d: got %h want %h", c, out_row, exp_q[0]);
                    end
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            next_cycle();
        end
        start = 1'b0;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL overflow_drain: %0d rows undelivered, want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    // Runs right after the overflow tile: overflow still set in cycle 0, the
    // rows=0 start clears it and pulses done next cycle without going busy.
    task automatic test_zero_rows();
        logic [3:0] st, ex;
        for (int c = 0; c < 4; c++) begin
            start = (c == 0); rows = '0; out_ready = 1'b1;
            drive(c, 0, 0, 0);
            @(negedge clk);
            st = {out_valid, busy, done, overflow};
            ex = {1'b0, 1'b0, (c == 1), (c == 0)};
            vectors++;
            if (st !== ex) begin
                miscompares++;
                $display("FAIL zero_rows c=%0d: valid/busy/done/ovf=%b want %b", c, st, ex);
            end
            next_cycle();
        end
        start = 1'b0;
    endtask

    // FIFO full at cycle 15 while ready rises: pushes and pops coincide, no loss.
    task automatic test_full_push_pop();
        logic [3:0] st, ex;
        for (int c = 0; c < 28; c++) begin
            start = (c == 0); rows = RW'(10); out_ready = (c >= 15);
            drive(c, 0, 10, 10);
            @(negedge clk);
            st = {out_valid, busy, done, overflow};
            ex = {(c >= 8 && c <= 24), (c >= 1 && c <= 25), (c == 25), 1'b0};
            vectors++;
            if (st !== ex) begin
                miscompares++;
                $display("FAIL full_push_pop_status c=%0d: valid/busy/done/ovf=%b want %b", c, st, ex);
            end
            if (out_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL full_push_pop_row c=%0d: got %h, want no row", c, out_row);
                end else begin
                    if (out_row !== exp_q[0]) begin
                        miscompares++;
                        $display("FAIL full_push_pop_row c=%0d: got %h want %h", c, out_row, exp_q[0]);
                    end
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            next_cycle();
        end
        start = 1'b0;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL full_push_pop_drain: %0d rows undelivered, want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    // Second start (rows=7) at cycle 3 must be ignored: same as nominal.
    task automatic test_ignored_start();
        logic [3:0] st, ex;
        for (int c = 0; c < 15; c++) begin
            start = (c == 0 || c == 3); rows = (c == 3) ? RW'(7) : RW'(3); out_ready = 1'b1;
            drive(c, 0, 3, 3);
            @(negedge clk);
            st = {out_valid, busy, done, overflow};
            ex = {(c >= 8 && c <= 10), (c >= 1 && c <= 11), (c == 11), 1'b0};
            vectors++;
            if (st !== ex) begin
                miscompares++;
                $display("FAIL ignored_start_status c=%0d: valid/busy/done/ovf=%b want %b", c, st, ex);
            end
            if (out_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL ignored_start_row c=%0d: got %h, want no row", c, out_row);
                end else begin
                    if (out_row !== exp_q[0]) begin
                        miscompares++;
                        $display("FAIL ignored_start_row c=%0d: got %h want %h", c, out_row, exp_q[0]);
                    end
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            next_cycle();
        end
        start = 1'b0;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL ignored_start_drain: %0d rows undelivered, want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    // rst during cycle 9: from cycle 10 everything is back to reset state.
    task automatic test_reset_mid_tile();
        logic [3:0] st, ex;
        for (int c = 0; c < 15; c++) begin
            start = (c == 0); rows = RW'(3); out_ready = 1'b1; rst = (c == 9);
            drive(c, 0, 3, 3);
            @(negedge clk);
            st = {out_valid, busy, done, overflow};
            ex = {(c == 8 || c == 9), (c >= 1 && c <= 9), 1'b0, 1'b0};
            vectors++;
            if (st !== ex) begin
                miscompares++;
                $display("FAIL reset_mid_status c=%0d: valid/busy/done/ovf=%b want %b", c, st, ex);
            end
            if (c >= 10) begin
                vectors++;
                if (out_row !== '0) begin
                    miscompares++;
                    $display("FAIL reset_mid_row c=%0d: got %h want 0", c, out_row);
                end
            end else if (out_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL reset_mid_row c=%0d: got %h, want no row", c, out_row);
                end else begin
                    if (out_row !== exp_q[0]) begin
                        miscompares++;
                        $display("FAIL reset_mid_row c=%0d: got %h want %h", c, out_row, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            next_cycle();
        end
        start = 1'b0;
        rst   = 1'b0;
        exp_q.delete();  // row 2 was in flight and is discarded by the reset
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_overflow();
        test_zero_rows();
        test_full_push_pop();
        test_ignored_start();
        test_reset_mid_tile();
        test_nominal();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/systolic_result_drain.md
# systolic_result_drain

Receive-side companion to the systolic array. Captures the diagonally skewed partial-sum stream leaving the bottom of the array and de-skews it into row-aligned result vectors. Buffers those vectors in a row FIFO and hands them to the downstream writer through a valid/ready handshake. Tracks tile progress with a counter FSM and flags results lost to back-pressure.

## Interface
- DATAWIDTH, 8, operand width; accumulator width ACCW = 3*DATAWIDTH
- N_SIZE, 32, array dimension (columns drained)
- LAT, N_SIZE, cycles from `start` to column-0/row-0 result at array output
- ROW_W, 9, width of tile row count (max 2^ROW_W-1 rows)
- FIFO_DEPTH, 8, row FIFO depth in aligned rows (power of 2)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse, same cycle tile row 0 enters array row 0
- rows  in  ROW_W  tile row count, sampled with accepted `start`
- col_in  in  [N_SIZE] x ACCW  array bottom outputs; column j
- out_row  out  [N_SIZE] x ACCW  aligned result row, FIFO head
- out_valid  out  1  out_row valid
- out_ready  in  1  downstream accepts; transfer when valid && ready
- busy  out  1  tile in progress (not IDLE)
- done  out  1  one-cycle pulse, tile fully delivered
- overflow  out  1  sticky: at least one aligned row dropped

## Operation
- Arrival law (fixed): result of tile row r, column j at col_in[j] in cycle t0+LAT+r+j (t0 = start cycle).
- De-skew: column j delayed N_SIZE-1-j cycles by a register chain; column N_SIZE-1 undelayed. Row r is aligned in cycle t0+LAT+N_SIZE-1+r.
- Delay chains shift every cycle, unconditionally; the array cannot stall.
- FSM states:
  - IDLE: accepted `start` with rows>0 -> WAIT, loading wait counter = LAT+N_SIZE-1. `start` with rows=0 -> `done` pulse next cycle, stay IDLE.
  - WAIT: decrement; at 0 -> CAPTURE with row counter = rows.
  - CAPTURE: push aligned row each cycle, decrement row counter; at last push -> DRAIN.
  - DRAIN: when FIFO empty -> IDLE, `done` pulse that cycle.
- `start` while busy is ignored: no state change, no effect on `rows` or `overflow`.
- Accepted `start` clears `overflow`.
- FIFO full on a push: row dropped, `overflow` set, row counter still decrements.
- Push and pop in the same cycle on a full FIFO: pop frees the entry; push succeeds, no overflow.
- Accumulator values pass through unmodified; no saturation or truncation.

## Timing
- Reset values: out_valid=0, busy=0, done=0, overflow=0, out_row=0, FIFO empty, delay chains 0, state IDLE.
- Reset asserted mid-tile: next cycle equals the reset state; in-flight rows discarded; no `done`.
- First out_valid in cycle t0+LAT+N_SIZE (FIFO write registered); with out_ready held high, rows emerge on consecutive cycles.
- out_row is stable while out_valid && !out_ready.
- `done` is asserted no earlier than the cycle after the final handshake. With ready held high: t0+LAT+N_SIZE+rows.
- busy is high from t0+1 through the `done` cycle inclusive.

## Structure
- Shared package `systolic_pkg`: ACCW localparam function, FSM state enum typedef, accumulator word typedef. The array and its feeder also use it.
- One sub-module: `row_fifo`, a synchronous FIFO of N_SIZE*ACCW-bit words with full/empty flags. Delay chains and FSM stay in the top.

## Test plan
Use N_SIZE=4, LAT=4, DATAWIDTH=8, FIFO_DEPTH=8.
- Reset then idle: out_valid/busy/done/overflow all 0 for 20 cycles with random col_in.
- start at cycle 0, rows=3; drive col_in[j] = 100*r+j at cycle 4+r+j; ready=1 -> out_row = {0,1,2,3}, {100..103}, {200..203} at cycles 8, 9, 10; done at cycle 11.
- Same tile, ready=0 until cycle 15 -> rows held with no loss, delivered at cycles 15-17, done at 18, overflow=0.
- rows=10, FIFO_DEPTH=8, ready=0 throughout capture -> overflow=1; first 8 rows delivered intact; done after FIFO empties; next start clears overflow.
- start pulse at cycle 3 of a busy tile -> ignored; output identical to the single-start run.
- rst at cycle 9 of a rows=3 tile -> cycle 10: out_valid=0, busy=0; no done; fresh tile afterwards behaves nominally.
